// File: rtl/alu_op_sequencer.sv
// Request FIFO plus IDLE/EXEC/RESP issue FSM in front of a combinational 32-bit ALU.
// Optional build macro ALU_SEQ_SEL_CHECK_EN: selects above 5 are flagged and their result zeroed.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_sel,
  input  logic        req_cin,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  output logic        alu_cin,
  input  logic [31:0] alu_y,
  input  logic [3:0]  alu_flags,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_y,
  output logic [3:0]  res_flags,
  output logic        res_err,
  output logic        busy
);
  localparam int DATA_W = 32;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_a   [DEPTH];
  logic [DATA_W-1:0] mem_b   [DEPTH];
  logic [3:0]        mem_sel [DEPTH];
  logic              mem_cin [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty;
  logic          push, pop, cap, consume;

  logic [DATA_W-1:0] alu_a_p0, alu_b_p0;
  logic [3:0]        alu_sel_p0;
  logic              alu_cin_p0;

  logic [DATA_W-1:0] res_y_p1;
  logic [3:0]        res_flags_p1;
  logic              vld_p1;

`ifdef ALU_SEQ_SEL_CHECK_EN
  logic err_p1;

  function automatic logic sel_illegal(input logic [3:0] sel);
    return sel > 4'd5;
  endfunction
`endif

  assign fifo_empty = (count == '0);
  assign req_ready  = (count != FULL_CNT);
  assign push       = req_valid && req_ready;
  assign busy       = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cap     = 1'b0;
    consume = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cap     = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (res_ready) begin
          consume = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: data only, validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= req_a;
      mem_b[wr_ptr]   <= req_b;
      mem_sel[wr_ptr] <= req_sel;
      mem_cin[wr_ptr] <= req_cin;
    end
  end

  // Stage p0: operation issued to the ALU, held until the next pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_p0   <= '0;
      alu_b_p0   <= '0;
      alu_sel_p0 <= '0;
      alu_cin_p0 <= 1'b0;
    end else if (pop) begin
      alu_a_p0   <= mem_a[rd_ptr];
      alu_b_p0   <= mem_b[rd_ptr];
      alu_sel_p0 <= mem_sel[rd_ptr];
      alu_cin_p0 <= mem_cin[rd_ptr];
    end
  end

  // Stage p1: ALU result captured at the end of EXEC, held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_y_p1     <= '0;
      res_flags_p1 <= '0;
    end else if (cap) begin
`ifdef ALU_SEQ_SEL_CHECK_EN
      if (sel_illegal(alu_sel_p0)) begin
        res_y_p1     <= '0;
        res_flags_p1 <= '0;
      end else begin
        res_y_p1     <= alu_y;
        res_flags_p1 <= alu_flags;
      end
`else
      res_y_p1     <= alu_y;
      res_flags_p1 <= alu_flags;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
`ifdef ALU_SEQ_SEL_CHECK_EN
      err_p1 <= 1'b0;
`endif
    end else if (cap) begin
      vld_p1 <= 1'b1;
`ifdef ALU_SEQ_SEL_CHECK_EN
      err_p1 <= sel_illegal(alu_sel_p0);
`endif
    end else if (consume) begin
      vld_p1 <= 1'b0;
`ifdef ALU_SEQ_SEL_CHECK_EN
      err_p1 <= 1'b0;
`endif
    end
  end

  assign alu_a     = alu_a_p0;
  assign alu_b     = alu_b_p0;
  assign alu_sel   = alu_sel_p0;
  assign alu_cin   = alu_cin_p0;
  assign res_y     = res_y_p1;
  assign res_flags = res_flags_p1;
  assign res_valid = vld_p1;
`ifdef ALU_SEQ_SEL_CHECK_EN
  assign res_err   = err_p1;
`else
  assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: table vectors, multi-cycle corner sequences and a random scoreboard run.
module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_sel;
  logic        req_cin;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic        alu_cin;
  logic [31:0] alu_y;
  logic [3:0]  alu_flags;
  logic        res_valid, res_ready;
  logic [31:0] res_y;
  logic [3:0]  res_flags;
  logic        res_err, busy;

  alu_op_sequencer #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_flags(res_flags), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 NOT A, others all-ones
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] sel, input logic cin);
    logic [32:0] s;
    logic [31:0] y;
    logic        c, v;
    s = '0; y = '0; c = 1'b0; v = 1'b0;
    case (sel)
      4'd0: y = a & b;
      4'd1: y = a | b;
      4'd2: begin
        s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        y = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      4'd3: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        y = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (y[31] != a[31]);
      end
      4'd4: y = a ^ b;
      4'd5: y = ~a;
      default: y = 32'hFFFF_FFFF;
    endcase
    return {c, y[31], (y == 32'd0), v, y};
  endfunction

  always_comb {alu_flags, alu_y} = alu_fn(alu_a, alu_b, alu_sel, alu_cin);

  typedef struct {
    logic [31:0] y;
    logic [3:0]  fl;
    logic        err;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic        cin;
    logic [31:0] y;
    logic [3:0]  fl;
    logic        err;
  } vec_t;

  function automatic res_t expect_res(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] sel, input logic cin);
    res_t r;
    logic [35:0] o;
    o = alu_fn(a, b, sel, cin);
    r.y = o[31:0]; r.fl = o[35:32]; r.err = 1'b0;
`ifdef ALU_SEQ_SEL_CHECK_EN
    if (sel > 4'd5) begin
      r.y = '0; r.fl = '0; r.err = 1'b1;
    end
`endif
    return r;
  endfunction

  res_t exp_q[$];
  int   fire_cyc[$];
  int   errors = 0, checks = 0, cyc = 0, n_acc = 0, n_fire = 0;
  int   base, f0, idx;
  logic [31:0] snap_y, snap_a;
  logic [3:0]  snap_fl, snap_sel;
  vec_t vec[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, return just after the rising edge
  task automatic cycle();
    res_t e;
    @(negedge clk);
    if (rst_n) begin
      if (req_valid && req_ready) begin
        exp_q.push_back(expect_res(req_a, req_b, req_sel, req_cin));
        n_acc++;
      end
      if (res_valid && res_ready) begin
        n_fire++;
        fire_cyc.push_back(cyc);
        chk("sb_expected_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_res_y", res_y, e.y);
          chk("sb_res_flags", 32'(res_flags), 32'(e.fl));
          chk("sb_res_err", 32'(res_err), 32'(e.err));
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_five();
    base = n_acc;
    res_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      idx = n_acc - base;
      req_valid = 1'b1;
      req_a = 32'h100 + 32'(idx);
      req_b = 32'h3;
      req_sel = 4'(idx);
      req_cin = 1'b0;
      cycle();
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    req_valid = 1'b0;
    for (int k = 0; k < 60 && (busy || exp_q.size() != 0); k++) cycle();
    chk("drain_idle", 32'(busy), 32'd0);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = '0; req_cin = 1'b0;
    res_ready = 1'b0;

    vec[0] = '{32'h0000_0001, 32'h0000_0001, 4'd0, 1'b0, 32'h0000_0001, 4'b0000, 1'b0};
    vec[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd2, 1'b0, 32'h0000_0000, 4'b1010, 1'b0};
    vec[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 4'd2, 1'b0, 32'h8000_0000, 4'b0101, 1'b0};
    vec[3] = '{32'h0000_0001, 32'h0000_0002, 4'd2, 1'b1, 32'h0000_0004, 4'b0000, 1'b0};
    vec[4] = '{32'h0000_0005, 32'h0000_0007, 4'd3, 1'b0, 32'hFFFF_FFFE, 4'b0100, 1'b0};
    vec[5] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd1, 1'b0, 32'hFFFF_FFFF, 4'b0100, 1'b0};
    vec[6] = '{32'hAAAA_5555, 32'hFFFF_0000, 4'd4, 1'b0, 32'h5555_5555, 4'b0000, 1'b0};
    vec[7] = '{32'h1234_5678, 32'h0000_0000, 4'd5, 1'b0, 32'hEDCB_A987, 4'b0100, 1'b0};
`ifdef ALU_SEQ_SEL_CHECK_EN
    vec[8] = '{32'h0000_0000, 32'h0000_0000, 4'd9, 1'b0, 32'h0000_0000, 4'b0000, 1'b1};
`else
    vec[8] = '{32'h0000_0000, 32'h0000_0000, 4'd9, 1'b0, 32'hFFFF_FFFF, 4'b0100, 1'b0};
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_res_err", 32'(res_err), 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_alu_sel", 32'(alu_sel), 32'd0);
    chk("reset_res_y", res_y, 32'd0);
    chk("reset_res_flags", 32'(res_flags), 32'd0);
    rst_n = 1'b1;
    cycle();

    // Single ops with latency checks
    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1;
      req_a = vec[i].a; req_b = vec[i].b; req_sel = vec[i].sel; req_cin = vec[i].cin;
      res_ready = 1'b1;
      cycle();
      req_valid = 1'b0;
      chk("lat_push_no_valid", 32'(res_valid), 32'd0);
      chk("lat_push_busy", 32'(busy), 32'd1);
      cycle();
      chk("lat_exec_no_valid", 32'(res_valid), 32'd0);
      chk("issue_alu_sel", 32'(alu_sel), 32'(vec[i].sel));
      chk("issue_alu_a", alu_a, vec[i].a);
      cycle();
      chk("vec_res_valid", 32'(res_valid), 32'd1);
      chk("vec_res_y", res_y, vec[i].y);
      chk("vec_res_flags", 32'(res_flags), 32'(vec[i].fl));
      chk("vec_res_err", 32'(res_err), 32'(vec[i].err));
      cycle();
      chk("vec_consumed", 32'(res_valid), 32'd0);
      chk("vec_idle", 32'(busy), 32'd0);
    end

    // Fill with backpressure, then hold in RESP
    fill_five();
    chk("fill_accepted", 32'(n_acc - base), 32'd5);
    chk("fill_req_ready_low", 32'(req_ready), 32'd0);
    chk("fill_res_valid", 32'(res_valid), 32'd1);
    snap_y = res_y; snap_fl = res_flags; snap_a = alu_a; snap_sel = alu_sel;
    chk("fill_first_alu_a", alu_a, 32'h100);
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_res_y", res_y, snap_y);
      chk("bp_res_flags", 32'(res_flags), 32'(snap_fl));
      chk("bp_alu_a", alu_a, snap_a);
      chk("bp_alu_sel", 32'(alu_sel), 32'(snap_sel));
    end
    f0 = n_fire;
    drain();
    chk("fill_results", 32'(n_fire - f0), 32'd5);

    // Back-to-back with res_ready held high
    fire_cyc.delete();
    f0 = n_fire;
    base = n_acc;
    res_ready = 1'b1;
    for (int k = 0; k < 60 && (n_acc - base) < 8; k++) begin
      idx = n_acc - base;
      req_valid = 1'b1;
      req_a = $urandom; req_b = $urandom;
      req_sel = 4'(idx % 6); req_cin = 1'($urandom_range(0, 1));
      cycle();
    end
    req_valid = 1'b0;
    drain();
    chk("b2b_results", 32'(n_fire - f0), 32'd8);
    for (int i = 1; i < fire_cyc.size(); i++)
      chk("b2b_interval", 32'(fire_cyc[i] - fire_cyc[i-1]), 32'd2);

    // Reset while EXEC with three queued
    fill_five();
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    chk("rst_pre_exec_valid", 32'(res_valid), 32'd0);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_y", res_y, 32'd0);
    exp_q.delete();
    f0 = n_fire;
    cycle();
    cycle();
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (10) cycle();
    chk("rst_no_result", 32'(n_fire - f0), 32'd0);
    chk("rst_stays_idle", 32'(busy), 32'd0);

    // Random traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_a = $urandom; req_b = $urandom;
      req_sel = 4'($urandom_range(0, 9));
      req_cin = 1'($urandom_range(0, 1));
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
